mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Responder end of the CPU's byte-wide memory bus: it serves the address/write/data outputs the core drives and returns read data one cycle later.
- Contains a byte-addressed main RAM plus the memory-mapped I/O window at mem_a[17:16]==2'b11.
- I/O window provides a UART TX FIFO with the io_buffer_full back-pressure flag, a UART RX FIFO, a cycle counter, and the program-stop port.
- Sits beside the cpu top, between the core bus and the UART/host link.

Parameters:
- RAM_ADDR_W, 17, RAM address width (128 KB).
- INIT_FILE, "", hex image loaded into RAM at elaboration; empty means no load.
- TX_DEPTH, 16, TX FIFO entries (power of two).
- RX_DEPTH, 8, RX FIFO entries (power of two).
- FULL_MARGIN, 2, free TX slots still left when io_buffer_full asserts.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  bus enable; when low the bus is ignored
- mem_a  in  32  bus address (bits 17:0 decoded)
- mem_wr  in  1  1 = write, 0 = read
- mem_dout  in  8  write data from the core
- mem_din  out  8  read data to the core
- io_buffer_full  out  1  TX FIFO near full
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  RX FIFO can accept
- halt  out  1  sticky, program stopped
- tx_overflow  out  1  sticky, TX byte dropped

Behaviour:
- Reset (rst_in low, async): mem_din=0, tx_valid=0, tx_data=0, io_buffer_full=0, rx_ready=1, halt=0, tx_overflow=0, counter=0, snapshot=0, both FIFOs empty. RAM contents are not reset. Reset during any operation discards the pending read and all FIFO contents.
- A bus transaction occurs on every rising edge where rdy_in=1.
- When rdy_in=0:
  - No RAM access, no FIFO push or pop from the bus.
  - mem_din and the counter hold.
  - TX drain and RX fill continue.
- Decode:
  - RAM when mem_a[17:16] in {00, 01}.
  - Unmapped when mem_a[17:16]==10: reads return 0x00, writes are dropped.
  - I/O when mem_a[17:16]==11, decoded on mem_a[2:0].
- Read latency: mem_din is registered and holds the data for the address presented in the previous enabled cycle. Write latency: one edge; a read of the same address on the next cycle returns the new byte.
- I/O write to 0x30000:
  - Nonzero byte is pushed to the TX FIFO.
  - 0x00 is ignored.
  - If the FIFO is full, the byte is dropped and tx_overflow is set.
- I/O write to 0x30004: sets halt and pushes 0x00 to the TX FIFO as the stop marker. The data value is ignored.
- After halt=1: all bus writes are ignored; reads are still served.
- I/O read of 0x30000:
  - RX FIFO non-empty: returns the head and pops it.
  - RX FIFO empty: returns 0x00, no pop.
- I/O read of 0x30004: returns counter[7:0] and latches the full counter into the snapshot in the same edge.
- I/O reads of 0x30005/6/7 return snapshot bytes 1/2/3.
- Other I/O offsets: reads return 0x00, writes are dropped.
- Counter: 32-bit, increments each cycle with rdy_in=1, wraps 0xFFFFFFFF->0.
- TX FIFO:
  - tx_valid = !empty; tx_data = head (registered FIFO output).
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop leave count unchanged; a push into a full FIFO with a simultaneous pop succeeds.
  - io_buffer_full is registered and equals (count >= TX_DEPTH-FULL_MARGIN) after each edge.
- RX FIFO:
  - rx_ready = !full.
  - Push when rx_valid && rx_ready.
  - Push and bus pop in the same cycle are both honoured.
- Pointer wrap: modulo depth; count is one bit wider than the pointers.

Decomposition:
- Shared package mem_io_pkg: IO_SEL=2'b11, IO_DATA_ADDR=18'h30000, IO_CLK_ADDR=18'h30004, region-decode function.
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, empty, full, count), instantiated twice for TX and RX.
- RAM is an inferred array inside the top.

Test Plan:
- Write 0xA5 to 0x00100, then read 0x00100 -> mem_din=0xA5 on the cycle after the read address.
- Writes of 'H', 0x00, 'i' to 0x30000 with tx_ready=1 -> tx stream is 0x48, 0x69 only.
- tx_ready=0, 14 writes to 0x30000 -> io_buffer_full=1 after the 14th edge.
  - 2 more writes are accepted; the 17th sets tx_overflow=1.
  - tx_ready=1 then drains exactly 16 bytes.
- Inject rx bytes 0x31, 0x32, then three reads of 0x30000 -> 0x31, 0x32, 0x00.
- Preload counter to 0x01020304, read 0x30004..0x30007 on consecutive cycles -> 0x04, 0x03, 0x02, 0x01, despite the counter advancing.
- Write 0x30004 -> halt=1, 0x00 emitted on tx. A later write of 0x77 to 0x00010 leaves RAM unchanged. rdy_in=0 for 5 cycles freezes the counter. Asserting rst_in low mid-drain clears tx_valid at once.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and address-region decode for the memory/IO responder.
package mem_io_pkg;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_NONE,
    REG_IO
  } region_e;

  function automatic region_e region_of(input logic [1:0] sel);
    if (sel == IO_SEL)
      return REG_IO;
    else if (sel == 2'b10)
      return REG_NONE;
    else
      return REG_RAM;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-wide core memory bus: the core is master, the responder is slave.
interface mem_io_responder_if;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;

  modport master (output rdy_in, mem_a, mem_wr, mem_dout, input mem_din);
  modport slave  (input rdy_in, mem_a, mem_wr, mem_dout, output mem_din);
endinterface

// File: rtl/mem_io_responder_sync_fifo.sv
// Power-of-two synchronous FIFO with register-based storage; dout shows the head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when a pop frees the head slot in the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end
endmodule

// File: rtl/mem_io_responder.sv
// Core-bus responder: byte RAM plus IO window (UART TX/RX FIFOs, cycle counter, stop port).
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W  = 17,
  parameter string       INIT_FILE   = "",
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  mem_io_responder_if.slave    bus,
  output logic                 io_buffer_full,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 halt,
  output logic                 tx_overflow
);
  localparam int unsigned TXC_W = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RXC_W = $clog2(RX_DEPTH) + 1;
  localparam logic [TXC_W-1:0] FULL_LEVEL = TXC_W'(TX_DEPTH - FULL_MARGIN);

  logic [7:0] ram [2**RAM_ADDR_W];

  region_e                 region;
  logic [2:0]              off;
  logic [RAM_ADDR_W-1:0]   ram_addr;
  logic                    en, rd, wr, io_rd, io_wr;
  logic [13:0]             unused_addr_hi;

  logic [31:0] cnt_q, snap_q;
  logic [7:0]  ram_rd_q, io_rd_q, io_rd_data;
  logic        src_ram_q, halt_q, ovf_q, io_full_q;

  logic             tx_push_req, tx_push, tx_pop, tx_drop, tx_empty, tx_full;
  logic [7:0]       tx_din;
  logic [TXC_W-1:0] tx_count, tx_count_next;
  logic             rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0]       rx_head;
  logic [RXC_W-1:0] unused_rx_count;

  assign region         = region_of(bus.mem_a[17:16]);
  assign off            = bus.mem_a[2:0];
  assign ram_addr       = bus.mem_a[RAM_ADDR_W-1:0];
  assign unused_addr_hi = bus.mem_a[31:18];
  assign en             = bus.rdy_in;
  assign rd             = en && !bus.mem_wr;
  assign wr             = en && bus.mem_wr && !halt_q;
  assign io_rd          = rd && (region == REG_IO);
  assign io_wr          = wr && (region == REG_IO);

  // Stop port always queues a 0x00 marker; zero bytes on the data port are not queued.
  assign tx_push_req = io_wr && ((off == IO_DATA_ADDR[2:0] && bus.mem_dout != 8'h00) ||
                                 off == IO_CLK_ADDR[2:0]);
  assign tx_din   = (off == IO_CLK_ADDR[2:0]) ? 8'h00 : bus.mem_dout;
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = tx_push_req && (!tx_full || tx_pop);
  assign tx_drop  = tx_push_req && !tx_push;
  assign tx_count_next = tx_count + TXC_W'(tx_push) - TXC_W'(tx_pop);

  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = io_rd && (off == IO_DATA_ADDR[2:0]) && !rx_empty;

  always_comb begin
    io_rd_data = 8'h00;
    if (region == REG_IO) begin
      case (off)
        IO_DATA_ADDR[2:0]: io_rd_data = rx_empty ? 8'h00 : rx_head;
        IO_CLK_ADDR[2:0]:  io_rd_data = cnt_q[7:0];
        3'd5:              io_rd_data = snap_q[15:8];
        3'd6:              io_rd_data = snap_q[23:16];
        3'd7:              io_rd_data = snap_q[31:24];
        default:           io_rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr && region == REG_RAM) ram[ram_addr] <= bus.mem_dout;
    if (en) ram_rd_q <= ram[ram_addr];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q     <= '0;
      snap_q    <= '0;
      io_rd_q   <= '0;
      src_ram_q <= 1'b0;
      halt_q    <= 1'b0;
      ovf_q     <= 1'b0;
      io_full_q <= 1'b0;
    end else begin
      if (en) begin
        cnt_q     <= cnt_q + 32'd1;
        src_ram_q <= rd && (region == REG_RAM);
        io_rd_q   <= rd ? io_rd_data : 8'h00;
        if (io_rd && off == IO_CLK_ADDR[2:0]) snap_q <= cnt_q;
      end
      if (io_wr && off == IO_CLK_ADDR[2:0]) halt_q <= 1'b1;
      if (tx_drop) ovf_q <= 1'b1;
      io_full_q <= (tx_count_next >= FULL_LEVEL);
    end
  end

  // RAM read data is selected after the register so the array keeps a plain sync-read port.
  assign bus.mem_din    = src_ram_q ? ram_rd_q : io_rd_q;
  assign halt           = halt_q;
  assign tx_overflow    = ovf_q;
  assign io_buffer_full = io_full_q;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk_in), .rst_n(rst_in), .push(tx_push), .pop(tx_pop), .din(tx_din),
    .dout(tx_data), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk_in), .rst_n(rst_in), .push(rx_push), .pop(rx_pop), .din(rx_data),
    .dout(rx_head), .empty(rx_empty), .full(rx_full), .count(unused_rx_count)
  );
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       io_buffer_full, tx_valid, rx_ready, halt, tx_overflow;
  logic [7:0] tx_data;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0]  tx_q [$];
  logic [31:0] model_cnt;

  mem_io_responder_if bus ();

  mem_io_responder #(.RAM_ADDR_W(17), .INIT_FILE(""), .TX_DEPTH(16), .RX_DEPTH(8),
                     .FULL_MARGIN(2)) dut (
    .clk_in(clk), .rst_in(rst_n), .bus(bus),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .halt(halt), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  // Expected counter: one increment per enabled edge since the last reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_cnt <= 32'd0;
    else if (bus.rdy_in) model_cnt <= model_cnt + 32'd1;
  end

  // Byte handed to the UART: valid && ready seen mid-cycle pops at the next edge.
  always @(negedge clk) begin
    #1;
    if (rst_n && tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic bus_op(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus.rdy_in = 1'b1; bus.mem_wr = wr; bus.mem_a = a; bus.mem_dout = d;
    @(negedge clk);
    bus.rdy_in = 1'b0; bus.mem_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rdy_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; bus.rdy_in = 1'b0; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.rdy_in = 1'b0; bus.mem_wr = 1'b0; bus.mem_a = '0; bus.mem_dout = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.mem_din !== 8'h00) begin tests_failed++; $display("FAIL reset_mem_din got %h want 00", bus.mem_din); end
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    tests_run++; if (io_buffer_full !== 1'b0) begin tests_failed++; $display("FAIL reset_io_full got %b want 0", io_buffer_full); end
    tests_run++; if (rx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
    tests_run++; if ({halt, tx_overflow} !== 2'b00) begin tests_failed++; $display("FAIL reset_halt_ovf got %b want 00", {halt, tx_overflow}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram();
    bus_op(1'b1, 32'h0000_0100, 8'hA5);
    bus_op(1'b0, 32'h0000_0100, 8'h00);
    tests_run++; if (bus.mem_din !== 8'hA5) begin tests_failed++; $display("FAIL ram_rd_100 got %h want a5", bus.mem_din); end
    bus_op(1'b1, 32'h0001_FFFF, 8'h5A);
    bus_op(1'b0, 32'h0001_FFFF, 8'h00);
    tests_run++; if (bus.mem_din !== 8'h5A) begin tests_failed++; $display("FAIL ram_rd_1ffff got %h want 5a", bus.mem_din); end
    bus_op(1'b1, 32'h0002_0100, 8'h11);
    bus_op(1'b0, 32'h0002_0100, 8'h00);
    tests_run++; if (bus.mem_din !== 8'h00) begin tests_failed++; $display("FAIL unmapped_rd got %h want 00", bus.mem_din); end
    bus_op(1'b0, 32'h0000_0100, 8'h00);
    tests_run++; if (bus.mem_din !== 8'hA5) begin tests_failed++; $display("FAIL unmapped_no_alias got %h want a5", bus.mem_din); end
    idle(1);
  endtask

  task automatic test_tx_stream();
    tx_q.delete();
    tx_ready = 1'b1;
    bus_op(1'b1, 32'h0003_0000, 8'h48);
    bus_op(1'b1, 32'h0003_0000, 8'h00);
    bus_op(1'b1, 32'h0003_0000, 8'h69);
    idle(4);
    tests_run++; if (tx_q.size() != 2) begin tests_failed++; $display("FAIL tx_stream_len got %0d want 2", tx_q.size()); end
    else begin
      tests_run++; if (tx_q[0] !== 8'h48 || tx_q[1] !== 8'h69) begin tests_failed++; $display("FAIL tx_stream_bytes got %h %h want 48 69", tx_q[0], tx_q[1]); end
    end
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL tx_stream_empty got %b want 0", tx_valid); end
  endtask

  task automatic test_tx_full();
    tx_q.delete();
    tx_ready = 1'b0;
    for (int i = 1; i <= 13; i++) bus_op(1'b1, 32'h0003_0000, 8'(8'h40 + i));
    tests_run++; if (io_buffer_full !== 1'b0) begin tests_failed++; $display("FAIL io_full_13 got %b want 0", io_buffer_full); end
    bus_op(1'b1, 32'h0003_0000, 8'h4E);
    tests_run++; if (io_buffer_full !== 1'b1) begin tests_failed++; $display("FAIL io_full_14 got %b want 1", io_buffer_full); end
    bus_op(1'b1, 32'h0003_0000, 8'h4F);
    bus_op(1'b1, 32'h0003_0000, 8'h50);
    tests_run++; if (tx_overflow !== 1'b0) begin tests_failed++; $display("FAIL tx_ovf_16 got %b want 0", tx_overflow); end
    bus_op(1'b1, 32'h0003_0000, 8'h51);
    tests_run++; if (tx_overflow !== 1'b1) begin tests_failed++; $display("FAIL tx_ovf_17 got %b want 1", tx_overflow); end
    tx_ready = 1'b1;
    idle(20);
    tests_run++; if (tx_q.size() != 16) begin tests_failed++; $display("FAIL tx_drain_len got %0d want 16", tx_q.size()); end
    else begin
      tests_run++; if (tx_q[0] !== 8'h41 || tx_q[15] !== 8'h50) begin tests_failed++; $display("FAIL tx_drain_ends got %h %h want 41 50", tx_q[0], tx_q[15]); end
    end
    tests_run++; if (io_buffer_full !== 1'b0) begin tests_failed++; $display("FAIL io_full_drained got %b want 0", io_buffer_full); end
  endtask

  task automatic test_rx();
    logic [7:0] exp;
    rx_valid = 1'b1; rx_data = 8'h31; @(negedge clk);
    rx_data = 8'h32; @(negedge clk);
    rx_valid = 1'b0;
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    tests_run++; if (bus.mem_din !== 8'h31) begin tests_failed++; $display("FAIL rx_rd0 got %h want 31", bus.mem_din); end
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    tests_run++; if (bus.mem_din !== 8'h32) begin tests_failed++; $display("FAIL rx_rd1 got %h want 32", bus.mem_din); end
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    tests_run++; if (bus.mem_din !== 8'h00) begin tests_failed++; $display("FAIL rx_rd_empty got %h want 00", bus.mem_din); end
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin rx_data = 8'(8'hA0 + i); @(negedge clk); end
    tests_run++; if (rx_ready !== 1'b0) begin tests_failed++; $display("FAIL rx_full_ready got %b want 0", rx_ready); end
    rx_data = 8'hFF; @(negedge clk);
    rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_op(1'b0, 32'h0003_0000, 8'h00);
      exp = 8'(8'hA0 + i);
      tests_run++; if (bus.mem_din !== exp) begin tests_failed++; $display("FAIL rx_fill_rd%0d got %h want %h", i, bus.mem_din, exp); end
    end
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    tests_run++; if (bus.mem_din !== 8'h00) begin tests_failed++; $display("FAIL rx_overfill_dropped got %h want 00", bus.mem_din); end
    tests_run++; if (rx_ready !== 1'b1) begin tests_failed++; $display("FAIL rx_ready_after got %b want 1", rx_ready); end
  endtask

  task automatic test_counter();
    logic [31:0] c;
    bus.mem_wr = 1'b0; bus.mem_a = 32'h0; bus.rdy_in = 1'b1;
    repeat (300) @(negedge clk);
    bus.rdy_in = 1'b0;
    c = model_cnt;
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    tests_run++; if (bus.mem_din !== c[7:0]) begin tests_failed++; $display("FAIL cnt_b0 got %h want %h", bus.mem_din, c[7:0]); end
    bus_op(1'b0, 32'h0003_0005, 8'h00);
    tests_run++; if (bus.mem_din !== c[15:8]) begin tests_failed++; $display("FAIL cnt_b1 got %h want %h", bus.mem_din, c[15:8]); end
    bus_op(1'b0, 32'h0003_0006, 8'h00);
    tests_run++; if (bus.mem_din !== c[23:16]) begin tests_failed++; $display("FAIL cnt_b2 got %h want %h", bus.mem_din, c[23:16]); end
    bus_op(1'b0, 32'h0003_0007, 8'h00);
    tests_run++; if (bus.mem_din !== c[31:24]) begin tests_failed++; $display("FAIL cnt_b3 got %h want %h", bus.mem_din, c[31:24]); end
    // freeze: counter advances only on the read edge itself
    c = model_cnt;
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    idle(5);
    tests_run++; if (bus.mem_din !== c[7:0]) begin tests_failed++; $display("FAIL din_hold got %h want %h", bus.mem_din, c[7:0]); end
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    c = c + 32'd1;
    tests_run++; if (bus.mem_din !== c[7:0]) begin tests_failed++; $display("FAIL cnt_frozen got %h want %h", bus.mem_din, c[7:0]); end
  endtask

  task automatic test_halt();
    bus_op(1'b1, 32'h0000_0010, 8'h33);
    tx_q.delete();
    tx_ready = 1'b1;
    bus_op(1'b1, 32'h0003_0004, 8'h99);
    tests_run++; if (halt !== 1'b1) begin tests_failed++; $display("FAIL halt_set got %b want 1", halt); end
    idle(3);
    bus_op(1'b1, 32'h0000_0010, 8'h77);
    bus_op(1'b1, 32'h0003_0000, 8'h5A);
    bus_op(1'b0, 32'h0000_0010, 8'h00);
    tests_run++; if (bus.mem_din !== 8'h33) begin tests_failed++; $display("FAIL halt_ram_kept got %h want 33", bus.mem_din); end
    idle(3);
    tests_run++; if (tx_q.size() != 1) begin tests_failed++; $display("FAIL halt_tx_len got %0d want 1", tx_q.size()); end
    else begin
      tests_run++; if (tx_q[0] !== 8'h00) begin tests_failed++; $display("FAIL halt_marker got %h want 00", tx_q[0]); end
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    tests_run++; if ({halt, tx_overflow} !== 2'b00) begin tests_failed++; $display("FAIL rst_clears_sticky got %b want 00", {halt, tx_overflow}); end
    bus_op(1'b0, 32'h0000_0100, 8'h00);
    tests_run++; if (bus.mem_din !== 8'hA5) begin tests_failed++; $display("FAIL ram_survives_rst got %h want a5", bus.mem_din); end
    tx_ready = 1'b0;
    bus_op(1'b1, 32'h0003_0000, 8'h61);
    bus_op(1'b1, 32'h0003_0000, 8'h62);
    bus_op(1'b1, 32'h0003_0000, 8'h63);
    tx_ready = 1'b1;
    @(posedge clk); #2;
    tests_run++; if (tx_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_drain_valid got %b want 1", tx_valid); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin tests_failed++; $display("FAIL async_rst_tx got %b/%h want 0/00", tx_valid, tx_data); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_discard_fifo got %b want 0", tx_valid); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx_stream();
    test_tx_full();
    test_rx();
    test_counter();
    test_halt();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
